mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the CPU datapath and a word-wide data memory with a chip-select/ack handshake.
- Store direction: narrows 32-bit register data to byte/halfword lanes with byte enables.
- Load direction: selects the addressed byte or halfword from the returned word, then sign- or zero-extends it to 32 bits.
- Sits between the EX/MEM stage and the data memory and replaces a single-cycle combinational memory path.

Parameters:
- AW, 32, address width.
- TO_CYCLES, 255, ack timeout in cycles; used only with MEMIF_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU access request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_uns  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, taken from bits [7:0] / [15:0] / [31:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, reserved size, or timeout; valid with rsp_valid.
- mem_cs  out  1  memory select, held until ack.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables, little-endian (bit0 = bits [7:0]).
- mem_addr  out  AW  word address: {req_addr[AW-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ack  in  1  memory completes the access this cycle.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - mem_cs=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0.
  - Reset mid-access abandons the transaction; no response is ever produced for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register all request fields.
  - Error condition: size=11, or half with addr[0]=1, or word with addr[1:0]!=0. If it holds, go to RESP with err=1 and issue no memory cycle.
  - Otherwise go to ACCESS.
- ACCESS:
  - req_ready=0; mem_cs=1; mem_we, mem_be, mem_addr, mem_wdata held stable until ack.
  - On mem_ack: latch the extended load result, drop mem_cs on the next edge, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - rsp_rdata and rsp_err stay held until the next response.
- Latency:
  - Accept at edge N. If ack is present in the first ACCESS cycle, rsp_valid is high in cycle N+2.
  - Each wait cycle before ack adds 1.
  - Minimum issue interval is 3 cycles.
- mem_ack is ignored outside ACCESS.
- Store lanes (o = addr[1:0]):
  - byte: be = 4'b0001<<o, wdata = {4{d[7:0]}}.
  - half: be = 4'b0011<<o, wdata = {2{d[15:0]}}.
  - word: be = 4'b1111.
- Load: be=4'b1111. Select the byte at rdata[8*o +: 8] or the half at rdata[16*o[1] +: 16]. Replicate bit 7/15 when req_uns=0, zeros when req_uns=1. Word loads pass through unchanged.

Optional Feature:
- MEMIF_TIMEOUT_EN defined:
  - An 8+ bit counter clears on ACCESS entry and increments every ACCESS cycle without ack.
  - When it reaches TO_CYCLES: drop mem_cs, go to RESP with rsp_err=1, rsp_rdata=0.
  - An ack arriving in that same cycle wins.
- Not defined: the unit waits for ack indefinitely; no counter logic is generated.

Decomposition:
- Shared defines header holds:
  - MEM_SIZE_BYTE/HALF/WORD encodings.
  - State encodings.
  - MEMIF_TIMEOUT_EN guard, alongside the existing EXT_* control encodings.
- One sub-module, load_ext: purely combinational lane select plus sign/zero extension.
  - Inputs: rdata, offset, size, uns.
  - Instantiated once; store alignment stays inline.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, ack after 2 cycles -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, cs held 3 cycles, rsp_err=0.
- LB addr=0x2001, rdata=0x12348056, signed -> rsp_rdata=0xFFFFFF80. Same with req_uns=1 -> 0x00000080.
- LH addr=0x2002, rdata=0x8001ABCD, signed -> 0xFFFF8001. LW addr=0x2000 -> 0x8001ABCD, rsp_valid exactly 2 cycles after accept with immediate ack.
- LW addr=0x2002, then SH addr=0x2001, then size=11 -> each gives rsp_err=1 with mem_cs never asserted.
- rstn low while in ACCESS with cs=1 -> cs=0 immediately (asynchronously), no rsp_valid; a request after release completes normally.
- MEMIF_TIMEOUT_EN, TO_CYCLES=4, no ack -> cs high 4 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, extension modes,
// FSM states and the request legality check.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Reserved size or an address not aligned to the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      MEM_SIZE_BYTE: err = 1'b0;
      MEM_SIZE_HALF: err = off[0];
      MEM_SIZE_WORD: err = (off != 2'b00);
      default:       err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load-path lane select: picks the addressed byte/halfword from the memory
// word and sign- or zero-extends it to 32 bits.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        fill;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = rdata[{offset[1], 4'b0000} +: 16];
    fill      = 1'b0;
    data      = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        fill = (uns == EXT_SIGN) && byte_lane[7];
        data = {{24{fill}}, byte_lane};
      end
      MEM_SIZE_HALF: begin
        fill = (uns == EXT_SIGN) && half_lane[15];
        data = {{16{fill}}, half_lane};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit with cs/ack memory handshake.
// Optional ack timeout enabled by defining MEMIF_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   load_data;

`ifdef MEMIF_TIMEOUT_EN
  localparam int CNT_W = (TO_CYCLES > 255) ? $clog2(TO_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  load_ext u_load_ext (
    .rdata  (mem_rdata),
    .offset (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .data   (load_data)
  );

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_size)
      MEM_SIZE_BYTE: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
`ifdef MEMIF_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d      = req_size;
          uns_d       = req_uns;
          off_d       = req_addr[1:0];
          req_ready_d = 1'b0;
          // Illegal requests answer with an error and never touch memory.
          if (access_err(req_size, req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            mem_cs_d    = 1'b1;
            mem_we_d    = req_we;
            mem_be_d    = req_we ? st_be : 4'b1111;
            mem_addr_d  = {req_addr[AW-1:2], 2'b00};
            mem_wdata_d = req_we ? st_wdata : '0;
`ifdef MEMIF_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_cs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_we_q ? '0 : load_data;
        end
`ifdef MEMIF_TIMEOUT_EN
        else if (cnt_q + 1'b1 == CNT_W'(TO_CYCLES)) begin
          state_d     = ST_RESP;
          mem_cs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        mem_cs_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
`ifdef MEMIF_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
`ifdef MEMIF_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized transactions
// compared against a transaction-level model of the load/store rules.
module tb_mem_access_unit;

  localparam int AW = 32;
`ifdef MEMIF_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_uns;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_cs;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  int vectors = 0;
  int miscompares = 0;

  // Expected view of the transaction in flight
  bit          exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  bit          exp_err;
  logic [31:0] exp_rdata;
  bit          expect_cs = 1'b0;
  bit          pend = 1'b0;

  // Observations captured by the driver for directed literal checks
  int          cs_cnt;
  int          lat;
  logic [31:0] rsp_seen;
  logic        err_seen;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(AW), .TO_CYCLES(TB_TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_uns   (req_uns),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic bit modelError(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] modelBe(input bit we, input logic [1:0] size, input logic [31:0] addr);
    int unsigned o;
    o = addr % 4;
    if (!we) return 4'd15;
    case (size)
      2'd0:    return 4'(1 << o);
      2'd1:    return 4'(3 << o);
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [1:0] size,
                                            input bit uns, input logic [31:0] addr);
    int unsigned o;
    logic [31:0] v;
    o = addr % 4;
    case (size)
      2'd0: begin
        v = (rd >> (8 * o)) & 32'hFF;
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'd1: begin
        v = (rd >> (16 * (o / 2))) & 32'hFFFF;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Per-cycle compare of memory-side and response-side outputs
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_cs) begin
        if (!expect_cs) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL cs_unexpected: got mem_cs=1, expected 0");
        end else begin
          checkOutput("mem_we", mem_we, exp_we);
          checkOutput("mem_be", mem_be, exp_be);
          checkOutput("mem_addr", mem_addr, exp_addr);
          if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
        end
      end
      if (rsp_valid) begin
        if (!pend) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid=1, expected 0");
        end else begin
          checkOutput("rsp_err", rsp_err, exp_err);
          checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        end
        pend = 1'b0;
      end
    end
  end

  // Issue one request and play memory with an ack after `delay` wait cycles.
  // Called at posedge+1 with the unit idle; returns at posedge+1 idle again.
  task automatic applyStimulus(input bit we, input logic [1:0] size, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd, input int delay);
    bit mis, tmo, got;
    int exp_lat, exp_cs, waited;
    checkOutput("req_ready_idle", req_ready, 1);
    mis = modelError(size, addr);
`ifdef MEMIF_TIMEOUT_EN
    tmo = !mis && (delay >= TB_TO);
`else
    tmo = 1'b0;
`endif
    exp_we    = we;
    exp_be    = modelBe(we, size, addr);
    exp_addr  = addr & 32'hFFFFFFFC;
    exp_wdata = modelWdata(size, wdata);
    exp_err   = mis || tmo;
    exp_rdata = (mis || tmo || we) ? 32'h0 : modelLoad(rd, size, uns, addr);
    expect_cs = !mis;
    pend      = 1'b1;
    exp_lat   = mis ? 1 : (tmo ? TB_TO + 1 : delay + 2);
    exp_cs    = mis ? 0 : (tmo ? TB_TO : delay + 1);

    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;

    waited = 0;
    cs_cnt = 0;
    got    = 1'b0;
    lat    = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      checkOutput("req_ready_busy", req_ready, 0);
      if (rsp_valid) begin
        got      = 1'b1;
        lat      = c;
        rsp_seen = rsp_rdata;
        err_seen = rsp_err;
      end else if (mem_cs) begin
        cs_cnt++;
        last_be    = mem_be;
        last_wdata = mem_wdata;
        last_addr  = mem_addr;
        if (waited == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        waited++;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rsp_wait: got no rsp_valid within 400 cycles, expected one");
    end else begin
      checkOutput("latency", lat, exp_lat);
      checkOutput("cs_cycles", cs_cnt, exp_cs);
    end
    expect_cs = 1'b0;
    @(posedge clk); #1;
    checkOutput("rsp_one_cycle", rsp_valid, 0);
    checkOutput("rsp_rdata_held", rsp_rdata, exp_rdata);
    checkOutput("rsp_err_held", rsp_err, exp_err);
    mem_ack = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_uns   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    #1 rstn = 1'b0;
    #20;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_mem_cs", mem_cs, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 2);
    checkOutput("sb_be", last_be, 4'b1000);
    checkOutput("sb_wdata", last_wdata, 32'hA5A5A5A5);
    checkOutput("sb_addr", last_addr, 32'h00001000);
    checkOutput("sb_cs_cycles", cs_cnt, 3);
    checkOutput("sb_err", err_seen, 0);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'h2001, 32'h0, 32'h12348056, 1);
    checkOutput("lb_signed", rsp_seen, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h2001, 32'h0, 32'h12348056, 0);
    checkOutput("lb_unsigned", rsp_seen, 32'h00000080);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001ABCD, 0);
    checkOutput("lh_signed", rsp_seen, 32'hFFFF8001);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'h8001ABCD, 0);
    checkOutput("lw_data", rsp_seen, 32'h8001ABCD);
    checkOutput("lw_latency", lat, 2);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h2002, 32'h0, 32'h11111111, 0);
    checkOutput("lw_mis_err", err_seen, 1);
    checkOutput("lw_mis_cs", cs_cnt, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h2001, 32'h0000BEEF, 32'h0, 0);
    checkOutput("sh_mis_err", err_seen, 1);
    checkOutput("sh_mis_cs", cs_cnt, 0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h2000, 32'h0, 32'h22222222, 0);
    checkOutput("size3_err", err_seen, 1);
    checkOutput("size3_rdata", rsp_seen, 0);

    // Reset in the middle of an access abandons it
    exp_we    = 1'b0;
    exp_be    = 4'hF;
    exp_addr  = 32'h3000;
    expect_cs = 1'b1;
    pend      = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_uns   = 1'b0;
    req_addr  = 32'h3000;
    mem_ack   = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("cs_before_reset", mem_cs, 1);
    #2;
    pend      = 1'b0;
    expect_cs = 1'b0;
    rstn      = 1'b0;
    #1;
    checkOutput("cs_async_clear", mem_cs, 0);
    checkOutput("ready_async", req_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("no_rsp_in_reset", rsp_valid, 0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h3006, 32'h0, 32'hCAFE1234, 1);
    checkOutput("after_reset_lhu", rsp_seen, 32'h0000CAFE);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end

`ifdef MEMIF_TIMEOUT_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hDEADBEEF, 100);
    checkOutput("to_err", err_seen, 1);
    checkOutput("to_rdata", rsp_seen, 0);
    checkOutput("to_cs_cycles", cs_cnt, 4);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hDEADBEEF, TB_TO - 1);
    checkOutput("to_ack_wins_err", err_seen, 0);
    checkOutput("to_ack_wins_rdata", rsp_seen, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
